// File: rtl/mac_lane_receiver.sv
// mac_lane_receiver: per-row signed dot product of pre-processed ifm/wfm beats, accumulated across passes
// into a row-indexed psum buffer and emitted on the final accumulation pass.
module mac_lane_receiver #(
    parameter int NUM_LANE   = 64,
    parameter int PSUM_DEPTH = 64,
    parameter int PSUM_W     = 34
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    output logic                     mac_pre_to_lane_i_ifm_ready,
    input  logic                     mac_pre_to_lane_o_ifm_valid,
    input  logic [11*NUM_LANE-1:0]   mac_pre_to_lane_o_ifm_data,
    input  logic [NUM_LANE-1:0]      mac_pre_to_lane_o_ifm_data_element_valid,
    input  logic                     mac_pre_to_lane_o_ifm_inter_end,
    input  logic                     mac_pre_to_lane_o_ifm_accum_end,
    input  logic [NUM_LANE-1:0]      mac_pre_to_lane_o_wfm_valid,
    input  logic [11*NUM_LANE-1:0]   mac_pre_to_lane_o_wfm_data,
    output logic                     o_psum_valid,
    output logic signed [PSUM_W-1:0] o_psum,
    output logic                     o_psum_last,
    input  logic                     i_psum_ready,
    output logic                     o_overflow
);
    localparam int RW = PSUM_DEPTH > 1 ? $clog2(PSUM_DEPTH) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(PSUM_DEPTH - 1);

    logic stall, accept;
    logic signed [17:0] prod [NUM_LANE];
    logic signed [17:0] s1_prod [NUM_LANE];
    logic [2*NUM_LANE-1:0] unused_sign_bits;
    logic s1_valid, s1_inter_end, s1_accum_end, s1_first, first_pass;
    logic [RW-1:0] s1_row, row;
    logic signed [PSUM_W-1:0] dot, sum_new;
    logic signed [PSUM_W-1:0] psum [PSUM_DEPTH];

    assign stall = o_psum_valid & ~i_psum_ready;
    assign mac_pre_to_lane_i_ifm_ready = i_reset & ~stall;
    assign accept = mac_pre_to_lane_o_ifm_valid & mac_pre_to_lane_i_ifm_ready;

    // The 9-bit field already carries the sign; the separate sign bit is redundant here.
    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
        logic [10:0] a, w;
        assign a = mac_pre_to_lane_o_ifm_data[l*11 +: 11];
        assign w = mac_pre_to_lane_o_wfm_data[l*11 +: 11];
        assign unused_sign_bits[2*l +: 2] = {a[9], w[9]};
        assign prod[l] = (a[10] | w[10] | ~mac_pre_to_lane_o_ifm_data_element_valid[l] |
                          ~mac_pre_to_lane_o_wfm_valid[l]) ? 18'sd0 : $signed(a[8:0]) * $signed(w[8:0]);
    end

    always_comb begin
        dot = '0;
        for (int i = 0; i < NUM_LANE; i++)
            dot = dot + {{(PSUM_W-18){s1_prod[i][17]}}, s1_prod[i]};
    end

    assign sum_new = s1_first ? dot : psum[s1_row] + dot;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            s1_valid     <= 1'b0;
            s1_prod      <= '{default: '0};
            s1_row       <= '0;
            s1_inter_end <= 1'b0;
            s1_accum_end <= 1'b0;
            s1_first     <= 1'b1;
            row          <= '0;
            first_pass   <= 1'b1;
            o_overflow   <= 1'b0;
            o_psum_valid <= 1'b0;
            o_psum       <= '0;
            o_psum_last  <= 1'b0;
        end else begin
            if (!stall) begin
                s1_valid     <= accept;
                o_psum_valid <= s1_valid & s1_accum_end;
                if (s1_valid & s1_accum_end) begin
                    o_psum      <= sum_new;
                    o_psum_last <= s1_inter_end;
                end
            end
            if (accept) begin
                s1_prod      <= prod;
                s1_row       <= row;
                s1_inter_end <= mac_pre_to_lane_o_ifm_inter_end;
                s1_accum_end <= mac_pre_to_lane_o_ifm_accum_end;
                s1_first     <= first_pass;
                row <= (mac_pre_to_lane_o_ifm_inter_end || row == LAST_ROW) ? '0 : row + RW'(1);
                if (!mac_pre_to_lane_o_ifm_inter_end && row == LAST_ROW) o_overflow <= 1'b1;
                if (mac_pre_to_lane_o_ifm_inter_end) first_pass <= mac_pre_to_lane_o_ifm_accum_end;
            end
        end
    end

    // Read and write both happen in stage 2, so consecutive beats to one row see fresh data.
    always_ff @(posedge i_clk) begin
        if (!stall && s1_valid && !s1_accum_end) psum[s1_row] <= sum_new;
    end
endmodule

// File: tb/tb_mac_lane_receiver.sv
// tb_mac_lane_receiver: table vectors, hand sequences and random passes checked against a beat-level model.
module tb_mac_lane_receiver;
    localparam int NL = 64;
    localparam logic [63:0] ALL = {64{1'b1}};

    logic clk = 1'b0;
    logic rst_n;
    logic ifm_ready, ifm_valid, inter_end, accum_end;
    logic [11*NL-1:0] ifm_data, wfm_data;
    logic [NL-1:0] elem_valid, wfm_valid;
    logic psum_valid, psum_last, overflow;
    logic psum_ready = 1'b1;
    logic signed [33:0] psum;

    mac_lane_receiver dut (
        .i_clk(clk), .i_reset(rst_n),
        .mac_pre_to_lane_i_ifm_ready(ifm_ready),
        .mac_pre_to_lane_o_ifm_valid(ifm_valid),
        .mac_pre_to_lane_o_ifm_data(ifm_data),
        .mac_pre_to_lane_o_ifm_data_element_valid(elem_valid),
        .mac_pre_to_lane_o_ifm_inter_end(inter_end),
        .mac_pre_to_lane_o_ifm_accum_end(accum_end),
        .mac_pre_to_lane_o_wfm_valid(wfm_valid),
        .mac_pre_to_lane_o_wfm_data(wfm_data),
        .o_psum_valid(psum_valid), .o_psum(psum), .o_psum_last(psum_last),
        .i_psum_ready(psum_ready), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic signed [33:0] v; bit last; } exp_t;
    typedef struct {
        logic signed [8:0] a, b;
        logic [63:0] ev, wv, iz, wz;
        longint exp;
    } vec_t;

    int checks = 0, failures = 0;
    bit mon_on = 0, rand_rdy = 0;
    logic signed [8:0] ia [NL];
    logic signed [8:0] wa [NL];
    logic [63:0] ev, wv, iz, wz;
    longint psum_m [64];
    int row_m = 0;
    bit first_m = 1;
    exp_t exp_q [$];
    exp_t mon_e;
    vec_t vt [10];

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void set_uni(input logic signed [8:0] a, input logic signed [8:0] b);
        for (int i = 0; i < NL; i++) begin ia[i] = a; wa[i] = b; end
        ev = ALL; wv = ALL; iz = '0; wz = '0;
    endfunction

    function automatic void rand_beat();
        for (int i = 0; i < NL; i++) begin ia[i] = 9'($urandom); wa[i] = 9'($urandom); end
        ev = {$urandom, $urandom} | {$urandom, $urandom};
        wv = {$urandom, $urandom} | {$urandom, $urandom};
        iz = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        wz = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    endfunction

    // Reference: whole-beat arithmetic on plain integers, row bookkeeping by the pass rules.
    function automatic void model_accept(input bit ie, input bit ae);
        longint dot = 0, nv;
        logic signed [33:0] t;
        for (int i = 0; i < NL; i++)
            if (!iz[i] && !wz[i] && ev[i] && wv[i]) dot += longint'(ia[i]) * longint'(wa[i]);
        nv = first_m ? dot : psum_m[row_m] + dot;
        t = nv[33:0];
        if (ae) exp_q.push_back('{t, ie});
        else psum_m[row_m] = longint'(t);
        if (ie) begin row_m = 0; first_m = ae; end
        else row_m = (row_m == 63) ? 0 : row_m + 1;
    endfunction

    task automatic send(input bit ie, input bit ae);
        int t = 0;
        for (int i = 0; i < NL; i++) begin
            ifm_data[i*11 +: 11] = {iz[i], ia[i][8], ia[i]};
            wfm_data[i*11 +: 11] = {wz[i], wa[i][8], wa[i]};
        end
        elem_valid = ev; wfm_valid = wv; inter_end = ie; accum_end = ae; ifm_valid = 1'b1;
        while (!ifm_ready && t < 1000) begin @(negedge clk); t++; end
        check("accept_timeout", ifm_ready, ifm_ready, 1);
        if (ifm_ready) model_accept(ie, ae);
        @(negedge clk);
        ifm_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input longint v, input bit l);
        int t = 0;
        while (!psum_valid && t < 10) begin @(negedge clk); t++; end
        check({name, "_valid"}, psum_valid, psum_valid, 1);
        check({name, "_psum"}, longint'(psum) == v, psum, v);
        check({name, "_last"}, psum_last == l, psum_last, l);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
        check("drain_empty", exp_q.size() == 0, exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        psum_ready = rand_rdy ? ($urandom_range(0, 2) == 0) : 1'b1;
    end

    logic signed [33:0] held_v;
    bit held_l, held;
    always @(negedge clk) begin
        if (!rst_n) held = 0;
        else if (mon_on) begin
            if (held) begin
                check("stall_hold", psum_valid && psum == held_v && psum_last == held_l, psum, held_v);
                held = 0;
            end
            if (psum_valid && psum_ready) begin
                check("mon_expected", exp_q.size() > 0, psum, 0);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("mon_psum", psum == mon_e.v, psum, mon_e.v);
                    check("mon_last", psum_last == mon_e.last, psum_last, mon_e.last);
                end
            end else if (psum_valid) begin
                held = 1; held_v = psum; held_l = psum_last;
            end
        end
    end

    initial begin
        vt[0] = '{9'sd1,    9'sd1,    ALL, ALL, '0, '0, 64};
        vt[1] = '{-9'sd256, -9'sd256, ALL, ALL, '0, '0, 4194304};
        vt[2] = '{9'sd3,    -9'sd5,   64'h0000_0000_FFFF_FFFF, ALL, '0, '0, -480};
        vt[3] = '{9'sd7,    9'sd2,    ALL, 64'hFF, '0, '0, 112};
        vt[4] = '{-9'sd1,   9'sd100,  ALL, ALL, 64'hFFFF, '0, -4800};
        vt[5] = '{9'sd255,  -9'sd256, ALL, ALL, '0, '0, -4177920};
        vt[6] = '{9'sd10,   9'sd10,   ALL, ALL, '0, 64'hFFFF_FFFF_FFFF_FFF0, 400};
        vt[7] = '{9'sd100,  -9'sd3,   {32{2'b10}}, 64'hFFFF_FFFF_0000_0000, '0, '0, -4800};
        vt[8] = '{9'sd0,    9'sd77,   ALL, ALL, '0, '0, 0};
        vt[9] = '{9'sd5,    9'sd6,    64'h0000_0000_FFFF_FFFF, 64'h0000_FFFF_FFFF_FFFF, 64'hF, '0, 840};
        rst_n = 1'b0; ifm_valid = 1'b0; inter_end = 1'b0; accum_end = 1'b0;
        ifm_data = '0; wfm_data = '0; elem_valid = '0; wfm_valid = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", psum_valid == 0, psum_valid, 0);
        check("rst_psum", psum == 0, psum, 0);
        check("rst_last", psum_last == 0, psum_last, 0);
        check("rst_ovf", overflow == 0, overflow, 0);
        check("rst_ready", ifm_ready == 0, ifm_ready, 0);
        rst_n = 1'b1; mon_on = 1;
        @(negedge clk);

        set_uni(9'sd1, 9'sd1);
        send(1, 1);
        check("lat_early", psum_valid == 0, psum_valid, 0);
        @(negedge clk);
        check("lat_valid", psum_valid == 1, psum_valid, 1);
        check("lat_psum", psum == 64, psum, 64);
        check("lat_last", psum_last == 1, psum_last, 1);

        for (int k = 0; k < 10; k++) begin
            set_uni(vt[k].a, vt[k].b);
            ev = vt[k].ev; wv = vt[k].wv; iz = vt[k].iz; wz = vt[k].wz;
            send(1, 1);
            expect_out($sformatf("vec%0d", k), vt[k].exp, 1);
        end

        for (int p = 0; p < 3; p++)
            for (int r = 0; r < 64; r++) begin rand_beat(); send(r == 63, p == 2); end
        drain();

        set_uni(-9'sd256, -9'sd256);
        send(1, 0); send(1, 0); send(1, 1);
        expect_out("extreme", 12582912, 1);

        rand_rdy = 1;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 32; r++) begin rand_beat(); send(r == 31, p == 1); end
        drain();
        rand_rdy = 0;
        repeat (2) @(negedge clk);

        set_uni(9'sd1, 9'sd1);
        send(1, 0);
        for (int k = 1; k <= 64; k++) begin
            send(0, 0);
            if (k == 63) check("ovf_before", overflow == 0, overflow, 0);
            if (k == 64) check("ovf_after", overflow == 1, overflow, 1);
        end
        send(1, 1);
        expect_out("ovf_row0", 192, 1);
        drain();

        send(1, 0); send(0, 0); send(0, 1);
        rst_n = 1'b0;
        exp_q.delete(); first_m = 1; row_m = 0;
        #1;
        check("mid_rst_valid", psum_valid == 0, psum_valid, 0);
        check("mid_rst_psum", psum == 0, psum, 0);
        check("mid_rst_ovf", overflow == 0, overflow, 0);
        check("mid_rst_ready", ifm_ready == 0, ifm_ready, 0);
        repeat (2) @(negedge clk);
        check("mid_rst_hold", psum_valid == 0, psum_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(1, 1);
        expect_out("post_rst", 64, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_lane_receiver.md
Name: mac_lane_receiver

Overview:
- Lane-side consumer of the MAC pre-processing unit's to-lane interface.
- Accepts pre-processed 11-bit ifm/wfm element vectors under a valid/ready handshake and forms a signed dot product per ifm row.
- Accumulates each row's partial sum across passes in a row-indexed psum buffer.
- On the accumulation-end pass, emits each row's final signed 34-bit sum on a valid/ready output for the int-to-fp32/bias post stage.

Parameters:
NUM_LANE, 64, elements per beat (ifm and wfm vector width in elements)
PSUM_DEPTH, 64, rows per inter pass (psum buffer entries)
PSUM_W, 34, signed psum/output width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-low reset
mac_pre_to_lane_i_ifm_ready  out  1  beat accept
mac_pre_to_lane_o_ifm_valid  in  1  ifm beat valid
mac_pre_to_lane_o_ifm_data  in  11*NUM_LANE  per element {is_zero, sign, signed 9-bit value}
mac_pre_to_lane_o_ifm_data_element_valid  in  NUM_LANE  per-element valid
mac_pre_to_lane_o_ifm_inter_end  in  1  last row of this pass
mac_pre_to_lane_o_ifm_accum_end  in  1  this pass is the final accumulation pass
mac_pre_to_lane_o_wfm_valid  in  NUM_LANE  per-lane weight valid
mac_pre_to_lane_o_wfm_data  in  11*NUM_LANE  per-lane weight, same format
o_psum_valid  out  1  final psum valid
o_psum  out  PSUM_W  signed final row sum
o_psum_last  out  1  final row of the set
i_psum_ready  in  1  downstream accept
o_overflow  out  1  sticky: row index wrapped without inter_end

Behaviour:
- Reset values: all outputs 0; row counter 0; first_pass = 1; pipeline stages invalid.
- Handshake:
  - Beat accepted when ifm_valid & ifm_ready.
  - wfm_valid does not gate acceptance. Lanes with wfm_valid[i] = 0 contribute 0.
  - ifm_ready = !(stall), where stall = o_psum_valid & !i_psum_ready.
  - ifm_ready is combinational and is 0 during reset.
- Stage 1 (registered on accept):
  - prod[i] = ifm[i][8:0] * wfm[i][8:0], signed 18-bit.
  - prod[i] is forced to 0 if any of: ifm is_zero bit[10], wfm is_zero, !element_valid[i], or !wfm_valid[i].
  - Captures row, inter_end, accum_end, first_pass.
- Stage 2 (advances when not stalled):
  - dot = sign-extended sum of the NUM_LANE products to PSUM_W.
  - new = first_pass ? dot : psum[row] + dot, wrapping two's complement at PSUM_W.
  - Read and write of psum[row] both occur in stage 2, so there is no hazard for back-to-back beats to the same row.
  - If accum_end = 0: psum[row] <= new; no output.
  - If accum_end = 1: o_psum <= new, o_psum_valid <= 1, o_psum_last <= inter_end. The psum buffer is not written.
- Latency: accept in cycle N, o_psum_valid in cycle N+2 when no stall.
- o_psum, o_psum_valid and o_psum_last hold while stalled. Valid drops the cycle after the transfer unless a new result is loaded the same cycle.
- Stall behaviour: stages 1 and 2 freeze; no beat is lost or duplicated.
- Row counter (on accept):
  - If inter_end: row <= 0.
  - Else if row == PSUM_DEPTH-1: row <= 0 and o_overflow <= 1 (sticky until reset).
  - Else: row <= row + 1.
- first_pass (on accept):
  - Cleared on an accepted beat with inter_end & !accum_end.
  - Set on an accepted beat with inter_end & accum_end.
  - A single-pass set (accum_end on pass 0) outputs the dot product directly.
- Asynchronous reset mid-operation discards in-flight beats and psum contents, and restores all reset values.

Test Plan:
- All elements = 1, all wfm_valid = 1, a 1-row set with inter_end = 1 and accum_end = 1 -> o_psum = 64, o_psum_last = 1, valid 2 cycles after accept.
- 3 passes × 64 rows with random 9-bit data, accum_end on pass 2 -> 64 outputs equal to the reference Σ over passes and lanes, last only on row 63.
- Half the lanes with element_valid = 0, a wfm_valid mask, and is_zero set on selected lanes -> masked lanes contribute 0. Extremes −256 × −256 on all 64 lanes over 3 passes -> 12582912 with no wrap.
- Random i_psum_ready (≈1/3 high) with continuous valid -> output sequence identical to the no-stall run, no drops, o_psum stable while stalled.
- 65 beats without inter_end -> o_overflow = 1 after beat 64, and row 0 is accumulated with the 65th beat.
- Reset asserted mid-pass, then a clean 1-row set -> outputs 0 during reset; post-reset result equals the dot product, with no stale accumulation.
